// File: rtl/tcam_pkg.sv
// tcam_pkg: shared defaults, arbiter FSM states and the in-flight tag type
// used by tcam_lookup_arb and its round-robin arbiter.
package tcam_pkg;

  localparam int DEF_KEY_W    = 4;
  localparam int DEF_IDX_W    = 4;
  localparam int DEF_TCAM_LAT = 4;

  // Requester ids are sized for the largest supported requester count so the
  // tag type does not depend on the instance parameters.
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2
  } arb_state_e;

  // One in-flight lookup: which requester owns the result coming back.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/tcam_lookup_arb_rr_arb.sv
// rr_arb: round-robin one-hot grant among NUM_REQ requesters. The search
// starts at the pointer and wraps; after a grant the pointer moves to the
// requester just past the winner, otherwise it holds.
module rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [NUM_REQ-1:0] hi, gnt_hi, gnt_lo;

  // Lowest requester at/above the pointer wins; if none, lowest overall (wrap)
  always_comb begin
    hi     = '0;
    gnt_hi = '0;
    gnt_lo = '0;
    for (int i = 0; i < NUM_REQ; i++)
      hi[i] = req[i] && (i >= int'(ptr));
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hi[i]) begin
        gnt_hi    = '0;
        gnt_hi[i] = 1'b1;
      end
      if (req[i]) begin
        gnt_lo    = '0;
        gnt_lo[i] = 1'b1;
      end
    end
    gnt = !en ? '0 : (|hi ? gnt_hi : gnt_lo);
    ptr_nxt = ptr;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
  end

  // Pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/tcam_lookup_arb.sv
// tcam_lookup_arb: shares one fixed-latency TCAM lookup pipeline between
// NUM_REQ requesters. A round-robin grant feeds one key per cycle into an
// issue register; a tag shift register follows each key through the TCAM so
// the returned index is steered to its owner. pause drains the pipeline and
// reports paused once nothing is in flight.
// Optional: define TCAM_ARB_CHECK_EN to build the sticky err_lat checker that
// flags results arriving without a tag or tags arriving without a result.
module tcam_lookup_arb
  import tcam_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int KEY_W    = DEF_KEY_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int TCAM_LAT = DEF_TCAM_LAT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*KEY_W-1:0] req_key,
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic                     tcam_key_vld,
  output logic [KEY_W-1:0]         tcam_key,
  input  logic                     tcam_res_vld,
  input  logic [IDX_W-1:0]         tcam_res,
  output logic [NUM_REQ-1:0]       rsp_vld,
  output logic [IDX_W-1:0]         rsp_idx,
  input  logic                     pause,
  output logic                     paused,
  output logic                     err_lat
);

  arb_state_e          state, state_nxt;
  logic                grant_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [KEY_W-1:0]    sel_key;
  logic [ID_W-1:0]     sel_id, issue_id;
  tag_t [TCAM_LAT:1]   tag_pipe;
  logic                pipe_empty;
  logic                deliver;
  logic [NUM_REQ-1:0]  ret_oh;

  // Grants only while running and not being asked to pause; held off while
  // reset is asserted so req_rdy reads 0 during reset.
  assign grant_en = reset && (state == RUN) && !pause;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (grant_en),
    .req   (req_vld),
    .gnt   (gnt)
  );

  assign req_rdy = gnt;

  // Key and id of the granted requester (gnt is one-hot or zero)
  always_comb begin
    sel_key = '0;
    sel_id  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        sel_key = req_key[i*KEY_W +: KEY_W];
        sel_id  = ID_W'(i);
      end
  end

  // Issue register driving the TCAM; key holds when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcam_key_vld <= 1'b0;
      tcam_key     <= '0;
      issue_id     <= '0;
    end else begin
      tcam_key_vld <= |gnt;
      if (|gnt) begin
        tcam_key <= sel_key;
        issue_id <= sel_id;
      end
    end
  end

  // Tag shift register; stage TCAM_LAT lines up with tcam_res_vld
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= '{valid: tcam_key_vld, id: issue_id};
      for (int s = 2; s <= TCAM_LAT; s++)
        tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // Nothing in flight: issue register and every tag stage empty
  always_comb begin
    pipe_empty = !tcam_key_vld;
    for (int s = 1; s <= TCAM_LAT; s++)
      if (tag_pipe[s].valid) pipe_empty = 1'b0;
  end

  // Results without a tag (e.g. launched before a reset) are dropped
  assign deliver = tcam_res_vld && tag_pipe[TCAM_LAT].valid;

  // One-hot owner of the result at the end of the tag pipe
  always_comb begin
    ret_oh = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ret_oh[i] = (tag_pipe[TCAM_LAT].id == ID_W'(i));
  end

  // Response register: strobe to owner, index holds between responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld <= '0;
      rsp_idx <= '0;
    end else begin
      rsp_vld <= deliver ? ret_oh : '0;
      if (deliver) rsp_idx <= tcam_res;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM next state: dropping pause always wins back to RUN
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (pause) state_nxt = DRAIN;
      DRAIN: begin
        if (!pause)          state_nxt = RUN;
        else if (pipe_empty) state_nxt = PAUSED;
      end
      PAUSED:  if (!pause) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // paused flop mirrors the PAUSED state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) paused <= 1'b0;
    else        paused <= (state_nxt == PAUSED);
  end

`ifdef TCAM_ARB_CHECK_EN
  // Sticky latency checker: result and last tag stage must always agree
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        err_lat <= 1'b0;
    else if (tcam_res_vld != tag_pipe[TCAM_LAT].valid) err_lat <= 1'b1;
  end
`else
  assign err_lat = 1'b0;
`endif

endmodule

// File: tb/tb_tcam_lookup_arb.sv
// tb_tcam_lookup_arb: random and directed stimulus against a cycle-level
// reference model; expected responses go to a scoreboard queue that a
// separate monitor drains whenever rsp_vld fires.
module tb_tcam_lookup_arb;

  localparam int N   = 4;
  localparam int KW  = 4;
  localparam int IW  = 4;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N*KW-1:0] req_key = '0;
  logic            pause = 1'b0;
  logic [N-1:0]    req_rdy;
  logic            tcam_key_vld;
  logic [KW-1:0]   tcam_key;
  logic            tcam_res_vld;
  logic [IW-1:0]   tcam_res;
  logic [N-1:0]    rsp_vld;
  logic [IW-1:0]   rsp_idx;
  logic            paused;
  logic            err_lat;

  logic            inj = 1'b0;
  logic [IW-1:0]   inj_idx = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tcam_lookup_arb #(.NUM_REQ(N), .KEY_W(KW), .IDX_W(IW), .TCAM_LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_vld      (req_vld),
    .req_key      (req_key),
    .req_rdy      (req_rdy),
    .tcam_key_vld (tcam_key_vld),
    .tcam_key     (tcam_key),
    .tcam_res_vld (tcam_res_vld),
    .tcam_res     (tcam_res),
    .rsp_vld      (rsp_vld),
    .rsp_idx      (rsp_idx),
    .pause        (pause),
    .paused       (paused),
    .err_lat      (err_lat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // TCAM stand-in: fixed latency, index = table lookup of the key; not reset,
  // so lookups launched before a reset still come back afterwards.
  logic [IW-1:0]  tbl [16];
  logic [LAT:1]   tm_vld = '0;
  logic [KW-1:0]  tm_key [LAT:1];
  always @(posedge clk) begin
    tm_vld    <= {tm_vld[LAT-1:1], tcam_key_vld};
    tm_key[1] <= tcam_key;
    for (int i = 2; i <= LAT; i++) tm_key[i] <= tm_key[i-1];
  end
  assign tcam_res_vld = tm_vld[LAT] | inj;
  assign tcam_res     = inj ? inj_idx : tbl[tm_key[LAT]];

  typedef struct {
    logic [N-1:0]  oh;
    logic [IW-1:0] idx;
    int            due;
  } exp_t;
  exp_t sb[$];

  // Reference model state: 0 run, 1 drain, 2 paused
  int  mode = 0;
  int  ptr = 0;
  bit  err_exp = 1'b0;
  bit  issued [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expectation, on time
  always @(negedge clk) begin
    if (reset) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("rsp_missing", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (rsp_vld != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_vld), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_owner", 32'(rsp_vld), 32'(e.oh));
          chk("rsp_idx", 32'(rsp_idx), 32'(e.idx));
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Check this cycle's outputs against the model, then advance the model
  task automatic eval();
    logic [N-1:0] eg;
    int g;
    bit tag, empty;
    eg = '0;
    g  = -1;
    if (mode == 0 && !pause)
      for (int j = 0; j < N; j++)
        if (g < 0 && req_vld[(ptr + j) % N]) g = (ptr + j) % N;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_rdy", 32'(req_rdy), 32'(eg));
    chk("paused", 32'(paused), 32'(mode == 2));
    chk("err_lat", 32'(err_lat), 32'(err_exp));
    tag = issued.exists(cyc - LAT - 1);
`ifdef TCAM_ARB_CHECK_EN
    if (tcam_res_vld != tag) err_exp = 1'b1;
`else
    if (tcam_res_vld != tag) err_exp = 1'b0;
`endif
    if (g >= 0) begin
      sb.push_back('{eg, tbl[req_key[g*KW +: KW]], cyc + LAT + 2});
      issued[cyc] = 1'b1;
      ptr = (g + 1) % N;
    end
    empty = 1'b1;
    for (int d = 1; d <= LAT + 1; d++)
      if (issued.exists(cyc - d)) empty = 1'b0;
    case (mode)
      0: if (pause) mode = 1;
      1: if (!pause) mode = 0; else if (empty) mode = 2;
      default: if (!pause) mode = 0;
    endcase
  endtask

  task automatic tick(input logic [N-1:0] v, input logic [N*KW-1:0] k,
                      input logic p, input logic ij);
    @(negedge clk);
    req_vld = v;
    req_key = k;
    pause   = p;
    inj     = ij;
    inj_idx = IW'($urandom);
    #1;
    eval();
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset   = 1'b0;
    req_vld = '0;
    pause   = 1'b0;
    inj     = 1'b0;
    #1;
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_key_vld", 32'(tcam_key_vld), 32'd0);
    chk("rst_key", 32'(tcam_key), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    chk("rst_paused", 32'(paused), 32'd0);
    chk("rst_err_lat", 32'(err_lat), 32'd0);
    sb.delete();
    issued.delete();
    mode    = 0;
    ptr     = 0;
    err_exp = 1'b0;
    repeat (hold) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    eval();
  endtask

  function automatic logic [N*KW-1:0] rk();
    return (N*KW)'($urandom);
  endfunction

  initial begin
    logic [N*KW-1:0] k1;
    logic p;
    for (int i = 0; i < 16; i++) tbl[i] = IW'($urandom);
    do_reset(2);

    // single request from requester 2, key D
    k1 = '0;
    k1[2*KW +: KW] = 4'hD;
    tick(4'b0100, k1, 1'b0, 1'b0);
    repeat (8) tick('0, '0, 1'b0, 1'b0);

    // all four held from reset: grants rotate 0,1,2,3,...
    do_reset(1);
    repeat (8) tick('1, rk(), 1'b0, 1'b0);
    repeat (8) tick('0, '0, 1'b0, 1'b0);

    // pause with lookups in flight, hold until paused, then resume
    repeat (3) tick('1, rk(), 1'b0, 1'b0);
    repeat (12) tick('1, rk(), 1'b1, 1'b0);
    repeat (3) tick('1, rk(), 1'b0, 1'b0);
    repeat (8) tick('0, '0, 1'b0, 1'b0);

    // pause dropped while draining
    repeat (3) tick('1, rk(), 1'b0, 1'b0);
    repeat (2) tick('1, rk(), 1'b1, 1'b0);
    repeat (3) tick('1, rk(), 1'b0, 1'b0);
    repeat (8) tick('0, '0, 1'b0, 1'b0);

    // random traffic with occasional pause toggles
    p = 1'b0;
    repeat (400) begin
      if ($urandom_range(0, 9) == 0) p = ~p;
      tick(N'($urandom), rk(), p, 1'b0);
    end
    repeat (10) tick('0, '0, 1'b0, 1'b0);

    // untagged result on an idle pipe
    tick('0, '0, 1'b0, 1'b1);
    repeat (6) tick('0, '0, 1'b0, 1'b0);

    // reset with lookups in flight; stale results must not respond
    repeat (3) tick('1, rk(), 1'b0, 1'b0);
    do_reset(1);
    repeat (10) tick('0, '0, 1'b0, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcam_lookup_arb.md
# tcam_lookup_arb

Shares the single 4-stage TCAM lookup pipeline between NUM_REQ requesters. Round-robin arbitration issues at most one key per cycle into the TCAM, a tag shift register tracks which requester owns each in-flight lookup, and the returned priority index is steered back to that requester. A pause/drain state machine quiesces the pipeline so a configuration controller can safely reload TCAM entries.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- KEY_W, 4, lookup key width
- IDX_W, 4, TCAM result index width
- TCAM_LAT, 4, cycles from TCAM key-valid to result-valid

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset); deassertion synchronised externally
- req_vld  in  NUM_REQ  per-requester lookup request
- req_key  in  NUM_REQ*KEY_W  keys, requester i at bits [i*KEY_W +: KEY_W]
- req_rdy  out  NUM_REQ  one-hot grant; transfer when req_vld[i] & req_rdy[i]
- tcam_key_vld  out  1  to TCAM data_in_vld
- tcam_key  out  KEY_W  to TCAM data_in
- tcam_res_vld  in  1  from TCAM tcam_out_vld
- tcam_res  in  IDX_W  from TCAM tcam_out
- rsp_vld  out  NUM_REQ  one-hot response strobe, no backpressure
- rsp_idx  out  IDX_W  returned index
- pause  in  1  request to stop issuing lookups
- paused  out  1  high when pipeline empty and no issue possible
- err_lat  out  1  sticky latency-mismatch error (see Configuration)

## Operation
- Reset values: req_rdy=0, tcam_key_vld=0, tcam_key=0, rsp_vld=0, rsp_idx=0, paused=0, err_lat=0, RR pointer=0, tag pipeline cleared, state RUN.
- Arbitration: combinational round-robin among req_vld; first set bit at or above pointer, wrapping. req_rdy only in RUN. On transfer, pointer <= granted+1 mod NUM_REQ; no transfer leaves pointer unchanged.
- req_rdy depends combinationally on req_vld; requesters hold req_key stable while req_vld & !req_rdy.
- Issue register: on transfer, tcam_key_vld<=1, tcam_key<=selected key; else tcam_key_vld<=0, tcam_key holds.
- Tag pipeline: TCAM_LAT stages of {valid, id}, fed from the issue register. Stage TCAM_LAT aligns with tcam_res_vld.
- Return: when tcam_res_vld, rsp_vld <= onehot(tag id), rsp_idx <= tcam_res; otherwise rsp_vld <= 0, rsp_idx holds.
- No-match returns index 0 (TCAM behaviour); the block does not distinguish it.
- FSM: RUN -> DRAIN when pause=1 (no grant in that cycle); DRAIN -> PAUSED when issue register and all tag stages invalid; PAUSED -> RUN when pause=0; DRAIN -> RUN if pause drops before empty. paused=1 only in PAUSED, registered.
- Reset mid-operation clears all in-flight tags; TCAM results returning after reset are discarded (no tag).

## Timing
- Transfer at edge t: tcam_key_vld in cycle t+1, tcam_res_vld in cycle t+1+TCAM_LAT, rsp_vld in cycle t+2+TCAM_LAT (6 cycles total at default).
- Throughput one lookup per cycle; back-to-back grants from different requesters return in issue order.
- pause asserted in cycle c: no req_rdy from cycle c; paused rises at most TCAM_LAT+2 cycles later.
- pause deasserted in PAUSED: req_rdy possible in the next cycle.

## Configuration
- TCAM_ARB_CHECK_EN defined: err_lat sets when tcam_res_vld=1 with last tag stage invalid, or last tag stage valid with tcam_res_vld=0; cleared only by reset. Result with no tag is dropped.
- Not defined: err_lat tied 0, checker logic absent; untagged results dropped.

## Structure
- Shared package tcam_pkg: KEY_W/IDX_W/TCAM_LAT defaults, FSM state enum (RUN, DRAIN, PAUSED), tag struct {valid, id}.
- One sub-module: rr_arb (NUM_REQ round-robin grant with pointer update).

## Test plan
- Single request: req 2 key 4'hD at edge 0 -> tcam_key_vld cycle 1, rsp_vld=4'b0100 with rsp_idx=tcam_res in cycle 6.
- All four req_vld held 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; responses in same order, each 6 cycles after grant.
- Pause with 3 lookups in flight -> req_rdy=0 immediately, all 3 responses delivered, paused=1, none granted until pause=0.
- Pause dropped during DRAIN -> returns to RUN, paused never asserts, grants resume next cycle.
- Reset pulse with lookups in flight -> all outputs 0 at once; stale tcam_res_vld after reset gives no rsp_vld.
- TCAM_ARB_CHECK_EN: inject tcam_res_vld with no issue -> err_lat=1 and stays 1; without macro err_lat stays 0.
